// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between three requesters.
// Each grant is held for at least HOLD_CYCLES clocks so the shown value stays readable.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [15:0] VAL0,
    input  logic [15:0] VAL1,
    input  logic [15:0] VAL2,
    output logic [2:0]  GNT,
    output logic        ACTIVE,
    output logic [3:0]  units,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands
);

    typedef enum logic {StIdle, StHold} state_e;

    localparam logic [25:0] HoldLast = 26'(HOLD_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  gnt_q;
    logic        active_q;
    logic [1:0]  gnt_idx_q;
    logic [1:0]  last_idx_q;
    logic [25:0] hold_cnt_q;
    logic [15:0] digits_q;

    logic [1:0]  cand1, cand2, win_idx;
    logic [15:0] win_val, cur_val;
    logic        expired, do_grant;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [15:0] sel_val(input logic [1:0] i, input logic [15:0] v0,
                                           input logic [15:0] v1, input logic [15:0] v2);
        case (i)
            2'd0:    return v0;
            2'd1:    return v1;
            default: return v2;
        endcase
    endfunction

    // Last grantee is searched last, so it only wins when nobody else is asking.
    always_comb begin
        cand1 = next_idx(last_idx_q);
        cand2 = next_idx(cand1);
        if (|(REQ & onehot(cand1))) begin
            win_idx = cand1;
        end else if (|(REQ & onehot(cand2))) begin
            win_idx = cand2;
        end else begin
            win_idx = last_idx_q;
        end
        win_val  = sel_val(win_idx, VAL0, VAL1, VAL2);
        cur_val  = sel_val(gnt_idx_q, VAL0, VAL1, VAL2);
        expired  = (hold_cnt_q == HoldLast);
        do_grant = (|REQ) && ((state_q == StIdle) || expired);
    end

    // A re-grant to the same requester leaves GNT unchanged and just restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            gnt_q      <= 3'b000;
            active_q   <= 1'b0;
            gnt_idx_q  <= 2'd2;
            last_idx_q <= 2'd2;
            hold_cnt_q <= 26'd0;
            digits_q   <= 16'h0000;
        end else if (do_grant) begin
            state_q    <= StHold;
            gnt_q      <= onehot(win_idx);
            active_q   <= 1'b1;
            gnt_idx_q  <= win_idx;
            last_idx_q <= win_idx;
            hold_cnt_q <= 26'd0;
            digits_q   <= win_val;
        end else if (state_q == StHold) begin
            if (!expired) begin
                hold_cnt_q <= hold_cnt_q + 26'd1;
                if (|(REQ & gnt_q)) begin
                    digits_q <= cur_val;
                end
            end else begin
                state_q  <= StIdle;
                gnt_q    <= 3'b000;
                active_q <= 1'b0;
            end
        end
    end

    assign GNT       = gnt_q;
    assign ACTIVE    = active_q;
    assign units     = digits_q[3:0];
    assign tens      = digits_q[7:4];
    assign hundreds  = digits_q[11:8];
    assign thousands = digits_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4; expected values are hand-derived.
module tb_display_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  REQ;
    logic [15:0] VAL0, VAL1, VAL2;
    logic [2:0]  GNT;
    logic        ACTIVE;
    logic [3:0]  units, tens, hundreds, thousands;

    int total = 0;
    int bad = 0;

    display_arbiter #(.HOLD_CYCLES(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .VAL0      (VAL0),
        .VAL1      (VAL1),
        .VAL2      (VAL2),
        .GNT       (GNT),
        .ACTIVE    (ACTIVE),
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, units};
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST  = 1'b1;
        REQ  = 3'b000;
        VAL0 = 16'h0000;
        VAL1 = 16'h0000;
        VAL2 = 16'h0000;
        @(negedge CLK);
        step();
        check("reset_gnt", 16'(GNT), 16'h0);
        check("reset_active", 16'(ACTIVE), 16'h0);
        check("reset_digits", digits(), 16'h0000);
        RST = 1'b0;

        // Single request, continuous across re-grants
        REQ  = 3'b001;
        VAL0 = 16'h1234;
        step();
        check("single_gnt", 16'(GNT), 16'h1);
        check("single_active", 16'(ACTIVE), 16'h1);
        check("single_digits", digits(), 16'h1234);
        for (int i = 0; i < 9; i++) begin
            step();
            check("single_regrant_gnt", 16'(GNT), 16'h1);
        end

        // Round-robin with exact 4-cycle grants and no gaps
        do_reset();
        REQ = 3'b111;
        VAL1 = 16'h2222;
        VAL2 = 16'h3333;
        step();
        for (int g = 0; g < 4; g++) begin
            logic [2:0] exp_gnt;
            exp_gnt = (g == 1) ? 3'b010 : (g == 2) ? 3'b100 : 3'b001;
            for (int c = 0; c < 4; c++) begin
                check("rr_gnt", 16'(GNT), 16'(exp_gnt));
                check("rr_active", 16'(ACTIVE), 16'h1);
                step();
            end
        end

        // Early drop: grant not withdrawn, digits freeze
        do_reset();
        REQ  = 3'b010;
        VAL1 = 16'h0042;
        step();
        check("drop_gnt0", 16'(GNT), 16'h2);
        check("drop_digits0", digits(), 16'h0042);
        REQ  = 3'b000;
        VAL1 = 16'h9999;
        for (int c = 1; c < 4; c++) begin
            step();
            check("drop_gnt_hold", 16'(GNT), 16'h2);
            check("drop_digits_hold", digits(), 16'h0042);
        end
        step();
        check("drop_gnt_idle", 16'(GNT), 16'h0);
        check("drop_active_idle", 16'(ACTIVE), 16'h0);
        check("drop_digits_idle", digits(), 16'h0042);
        step();
        check("idle_digits_keep", digits(), 16'h0042);

        // Live tracking with one-cycle lag, also across a re-grant
        do_reset();
        REQ  = 3'b100;
        VAL2 = 16'h0007;
        step();
        check("track_gnt", 16'(GNT), 16'h4);
        check("track_units0", 16'(units), 16'h7);
        for (int i = 1; i <= 6; i++) begin
            VAL2 = 16'h0007 + 16'(i);
            check("track_lag", 16'(units), 16'(7 + i - 1));
            step();
            check("track_units", 16'(units), 16'(7 + i));
        end
        check("track_gnt_end", 16'(GNT), 16'h4);

        // Reset mid-hold, then requester 1 first for REQ=110
        do_reset();
        REQ  = 3'b001;
        VAL0 = 16'h5678;
        step();
        step();
        RST = 1'b1;
        step();
        check("midrst_gnt", 16'(GNT), 16'h0);
        check("midrst_active", 16'(ACTIVE), 16'h0);
        check("midrst_digits", digits(), 16'h0000);
        RST  = 1'b0;
        REQ  = 3'b110;
        VAL1 = 16'h0ABC;
        step();
        check("midrst_first_gnt", 16'(GNT), 16'h2);
        check("midrst_first_digits", digits(), 16'h0ABC);

        // Fairness: short pulse on requester 2 inside requester 0's hold is lost
        do_reset();
        REQ  = 3'b001;
        VAL0 = 16'h1111;
        step();
        check("fair_gnt0", 16'(GNT), 16'h1);
        REQ = 3'b101;
        step();
        check("fair_gnt1", 16'(GNT), 16'h1);
        step();
        check("fair_gnt2", 16'(GNT), 16'h1);
        REQ = 3'b001;
        for (int c = 0; c < 5; c++) begin
            step();
            check("fair_regrant", 16'(GNT), 16'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit multiplexed seven-segment display between three requesters: a counter, the debounced-button tally and a status code. It drives the display driver's `units`/`tens`/`hundreds`/`thousands` inputs. Grants are round-robin with a guaranteed minimum on-screen hold time, so each requester's value stays readable before the display switches to the next one.

## Interface
- `HOLD_CYCLES`, default 50_000_000: minimum grant duration in CLK cycles (1 s at 50 MHz). Legal range is 2 to 2^26-1.
- `CLK`  in  1: system clock; all state updates on the rising edge.
- `RST`  in  1: synchronous reset, active-high.
- `REQ`  in  3: per-requester request; bit i belongs to requester i. Level-sensitive.
- `VAL0`, `VAL1`, `VAL2`  in  16 each: requester value as four nibbles, [3:0] units up to [15:12] thousands. Passed through unchecked, so non-BCD nibbles go out unchanged.
- `GNT`  out  3: registered one-hot grant, or all-zero when idle.
- `ACTIVE`  out  1: registered; high while in HOLD.
- `units`, `tens`, `hundreds`, `thousands`  out  4 each: registered digit nibbles sent to the display driver.

## Operation
- The arbiter is a two-state FSM: IDLE and HOLD.
- Registers:
  - `gnt_idx` (2 bits): current grantee.
  - `last_idx` (2 bits): most recent grantee.
  - `hold_cnt`: 26-bit counter.
  - Four 4-bit digit registers.
- Round-robin search order is `last_idx`+1, `last_idx`+2, `last_idx` (mod 3). The last grantee has the lowest priority.
- Reset (RST=1 at an edge, from any state, mid-hold included):
  - state=IDLE, `GNT`=000, `ACTIVE`=0, all digits=0, `hold_cnt`=0, `last_idx`=2.
  - With `last_idx`=2, requester 0 has first priority.
- IDLE:
  - If any `REQ` bit is high, pick winner w by the search order.
  - Next edge: state=HOLD, `GNT`=onehot(w), `gnt_idx`=`last_idx`=w, digits load VALw, `hold_cnt`=0.
  - If no `REQ` bit is high, the digits keep their last values. The display shows the final value of the previous grantee.
- HOLD, before expiry (`hold_cnt` < HOLD_CYCLES-1):
  - `hold_cnt` increments.
  - Digits reload VAL[`gnt_idx`] every edge while `REQ`[`gnt_idx`]=1. This gives a live value.
  - If `REQ`[`gnt_idx`]=0, the digits freeze. The grant is not withdrawn early.
- HOLD, at expiry (`hold_cnt`=HOLD_CYCLES-1), evaluated on that edge:
  - Another requester is high: rotate to winner w by the search order. `GNT`, digits and `gnt_idx` update as in IDLE, and `hold_cnt`=0.
  - Only the current grantee is high: re-grant the same requester. `GNT` stays unchanged and continuous, `hold_cnt`=0, digits keep tracking.
  - No `REQ` bit high: state=IDLE, `GNT`=000, `ACTIVE`=0. Digits hold.
- A request that rises and falls entirely within another requester's hold is lost. The arbiter does not latch requests.

## Timing
- Grant latency: `REQ` high in IDLE at edge k gives `GNT`, `ACTIVE` and digits valid after edge k. That is one cycle.
- Each grant lasts exactly HOLD_CYCLES cycles, then either re-grants or switches on the following edge.
- No idle gap occurs between consecutive grants.
- Digit tracking latency is one cycle (VAL sampled at edge k appears after edge k).
- `GNT` is never multi-hot and never changes except at expiry or on leaving IDLE.
- RST takes precedence over every other event at the same edge.

## Test plan
Run all scenarios with HOLD_CYCLES=4.
- **Single request:** after reset, `REQ`=001 held with VAL0=16'h1234 → one cycle later `GNT`=001, `ACTIVE`=1, thousands/hundreds/tens/units=1/2/3/4. `GNT` stays 001 continuously across re-grants.
- **Round-robin:** after reset, `REQ`=111 → `GNT` sequence is 001, 010, 100, 001, with each grant lasting exactly 4 cycles and no gap between grants.
- **Early drop:** grant requester 1 with VAL1=16'h0042, then drop `REQ`[1] after cycle 1 while changing VAL1=16'h9999 → digits stay 0,0,4,2 and `GNT`=010 until cycle 4. After that `GNT`=000, `ACTIVE`=0, and digits still read 0042.
- **Live tracking:** while granted requester 2, increment VAL2 each cycle from 16'h0007 → units follow with exactly one cycle lag.
- **Reset mid-hold:** assert RST during cycle 2 of a grant → next edge `GNT`=000, `ACTIVE`=0, digits=0. After release, `REQ`=110 grants requester 1 first.
- **Fairness:** `REQ`[0] constant, `REQ`[2] pulsed high only during cycles 1–2 of requester 0's hold → requester 2 is never granted, and requester 0 is re-granted at expiry.
